// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory interface.
// Also used by the CPU-side stall logic, so the state encoding is fixed here.
//
// state   | meaning
// IDLE    | waiting for MemRead/MemWrite; captures the request on the clock edge
// WAIT    | counting down inserted wait states; inputs ignored
// RESPOND | Ready pulse; captured request executes on the closing edge
package cpu_mem_pkg;

  localparam int DATA_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_t;

endpackage

// File: rtl/data_memory_responder_if.sv
// CPU data-memory bus: request strobes from the CPU, completion from the memory.
interface data_memory_responder_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 24
);
  logic                  MemRead;
  logic                  MemWrite;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [DATA_WIDTH-1:0] ReadData;
  logic                  Ready;
  logic                  Busy;
  logic                  Error;

  modport master (
    output MemRead, MemWrite, Address, WriteData,
    input  ReadData, Ready, Busy, Error
  );

  modport slave (
    input  MemRead, MemWrite, Address, WriteData,
    output ReadData, Ready, Busy, Error
  );
endinterface

// File: rtl/word_ram.sv
// Single-port word RAM: synchronous write, registered read, no reset.
module word_ram #(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  Clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write when enabled; the read port registers the addressed word every edge.
  always_ff @(posedge Clock) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_memory_responder.sv
// Responder end of the CPU data-memory interface.
// Accepts one load/store, waits WAIT_STATES cycles, then pulses Ready for one
// cycle. Conflicting strobes or an address beyond DEPTH complete with Error
// and never touch the RAM.
//
// state   | meaning
// IDLE    | no request outstanding; a strobe on the clock edge is accepted
// WAIT    | wait-state countdown; bus inputs are ignored
// RESPOND | Ready (and Error if rejected); write commits on the closing edge
module data_memory_responder #(
  parameter int DATA_WIDTH  = cpu_mem_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input logic                    Clock,
  input logic                    Reset,
  data_memory_responder_if.slave bus
);
  import cpu_mem_pkg::*;

  localparam logic [3:0]          WS_L    = 4'(WAIT_STATES);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  rd_q, wr_q, err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  accept;
  logic                  req_err;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign accept  = (state_q == IDLE) && (bus.MemRead || bus.MemWrite);
  assign req_err = (bus.MemRead && bus.MemWrite) || ({1'b0, bus.Address} >= DEPTH_L);

  // With zero wait states the RAM read happens on the accept edge itself,
  // so the RAM must see the live address while the request is being accepted.
  assign ram_addr = accept ? bus.Address : addr_q;
  assign ram_we   = (state_q == RESPOND) && wr_q && !err_q;

  // State and wait-state counter.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request (and its validity) on the accept edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      rd_q    <= bus.MemRead;
      wr_q    <= bus.MemWrite;
      err_q   <= req_err;
      addr_q  <= bus.Address;
      wdata_q <= bus.WriteData;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = WS_L;
          state_d = (WS_L == 4'd0) ? RESPOND : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESPOND;
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  word_ram #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .Clock (Clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Bus outputs; ReadData is forced to zero outside a successful load response.
  always_comb begin
    bus.Ready    = (state_q == RESPOND);
    bus.Busy     = (state_q != IDLE);
    bus.Error    = (state_q == RESPOND) && err_q;
    bus.ReadData = ((state_q == RESPOND) && rd_q && !err_q) ? ram_rdata : '0;
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: three instances cover
// WAIT_STATES=2/DEPTH=200, WAIT_STATES=0/DEPTH=256 and WAIT_STATES=1/DEPTH=256.
module tb_data_memory_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(24)) b0 ();
  data_memory_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(24)) b1 ();
  data_memory_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(24)) b2 ();

  data_memory_responder #(.DATA_WIDTH(24), .ADDR_WIDTH(8), .DEPTH(200), .WAIT_STATES(2))
    u0 (.Clock(clk), .Reset(rst), .bus(b0.slave));
  data_memory_responder #(.DATA_WIDTH(24), .ADDR_WIDTH(8), .DEPTH(256), .WAIT_STATES(0))
    u1 (.Clock(clk), .Reset(rst), .bus(b1.slave));
  data_memory_responder #(.DATA_WIDTH(24), .ADDR_WIDTH(8), .DEPTH(256), .WAIT_STATES(1))
    u2 (.Clock(clk), .Reset(rst), .bus(b2.slave));

  logic        tb_rd = 1'b0;
  logic        tb_wr = 1'b0;
  logic [7:0]  tb_addr = 8'h00;
  logic [23:0] tb_wdata = 24'h0;
  int          sel = 0;

  assign b0.MemRead   = tb_rd && (sel == 0);
  assign b0.MemWrite  = tb_wr && (sel == 0);
  assign b0.Address   = tb_addr;
  assign b0.WriteData = tb_wdata;
  assign b1.MemRead   = tb_rd && (sel == 1);
  assign b1.MemWrite  = tb_wr && (sel == 1);
  assign b1.Address   = tb_addr;
  assign b1.WriteData = tb_wdata;
  assign b2.MemRead   = tb_rd && (sel == 2);
  assign b2.MemWrite  = tb_wr && (sel == 2);
  assign b2.Address   = tb_addr;
  assign b2.WriteData = tb_wdata;

  logic        m_ready, m_err, m_busy;
  logic [23:0] m_rdata;

  always_comb begin
    m_ready = b0.Ready;
    m_err   = b0.Error;
    m_busy  = b0.Busy;
    m_rdata = b0.ReadData;
    if (sel == 1) begin
      m_ready = b1.Ready;
      m_err   = b1.Error;
      m_busy  = b1.Busy;
      m_rdata = b1.ReadData;
    end else if (sel == 2) begin
      m_ready = b2.Ready;
      m_err   = b2.Error;
      m_busy  = b2.Busy;
      m_rdata = b2.ReadData;
    end
  end

  typedef struct {
    int          cyc;
    logic        err;
    logic [23:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push(int c, logic er, logic [23:0] d);
    exp_t e;
    e.cyc  = c;
    e.err  = er;
    e.data = d;
    sb.push_back(e);
  endfunction

  // Monitor: every Ready pops one expectation; outside Ready the outputs must be quiet.
  always @(negedge clk) begin
    exp_t e;
    if (m_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got Ready=1 expected no response (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("ready_cycle", cyc, e.cyc);
        chk("ready_error", {31'b0, m_err}, {31'b0, e.err});
        chk("ready_rdata", {8'b0, m_rdata}, {8'b0, e.data});
      end
    end else begin
      chk("idle_rdata", {8'b0, m_rdata}, 32'h0);
      chk("idle_error", {31'b0, m_err}, 32'h0);
    end
  end

  // One request: accepted on the next rising edge, strobes dropped afterwards
  // and inputs scrambled while the responder is busy.
  task automatic issue(input int ws, input logic rd, input logic wr, input logic [7:0] a,
                       input logic [23:0] d, input logic e_err, input logic [23:0] e_data);
    @(negedge clk);
    tb_rd    = rd;
    tb_wr    = wr;
    tb_addr  = a;
    tb_wdata = d;
    push(cyc + 1 + ws, e_err, e_data);
    @(negedge clk);
    tb_rd    = 1'b0;
    tb_wr    = 1'b0;
    tb_addr  = ~a;
    tb_wdata = ~d;
    repeat (ws + 1) @(negedge clk);
  endtask

  initial begin
    int nb;
    int c0;

    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      chk("reset_busy",  {31'b0, m_busy},  32'h0);
      chk("reset_ready", {31'b0, m_ready}, 32'h0);
      chk("reset_error", {31'b0, m_err},   32'h0);
      chk("reset_rdata", {8'b0, m_rdata},  32'h0);
    end
    sel = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // WAIT_STATES=2, DEPTH=200
    issue(2, 1'b0, 1'b1, 8'h10, 24'hA5C3F0, 1'b0, 24'h0);
    issue(2, 1'b1, 1'b0, 8'h10, 24'h0,      1'b0, 24'hA5C3F0);
    issue(2, 1'b0, 1'b1, 8'h20, 24'h0F0F0F, 1'b0, 24'h0);
    issue(2, 1'b1, 1'b1, 8'h20, 24'h123456, 1'b1, 24'h0);
    issue(2, 1'b1, 1'b0, 8'h20, 24'h0,      1'b0, 24'h0F0F0F);
    issue(2, 1'b0, 1'b1, 8'hC8, 24'hABCDEF, 1'b1, 24'h0);
    issue(2, 1'b1, 1'b0, 8'hC8, 24'h0,      1'b1, 24'h0);
    issue(2, 1'b0, 1'b1, 8'hC7, 24'hC7C7C7, 1'b0, 24'h0);
    issue(2, 1'b1, 1'b0, 8'hC7, 24'h0,      1'b0, 24'hC7C7C7);
    issue(2, 1'b0, 1'b1, 8'h05, 24'h111111, 1'b0, 24'h0);

    // Store dropped by a reset during WAIT; no response is expected.
    @(negedge clk);
    tb_wr = 1'b1; tb_addr = 8'h05; tb_wdata = 24'hFFFFFF;
    @(negedge clk);
    tb_wr = 1'b0;
    chk("busy_before_reset", {31'b0, m_busy}, 32'h1);
    rst = 1'b1;
    #1;
    chk("busy_on_reset", {31'b0, m_busy}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    issue(2, 1'b1, 1'b0, 8'h05, 24'h0, 1'b0, 24'h111111);

    // WAIT_STATES=0
    sel = 1;
    issue(0, 1'b0, 1'b1, 8'hFF, 24'hDEADBE, 1'b0, 24'h0);
    @(negedge clk);
    tb_rd = 1'b1; tb_addr = 8'hFF;
    push(cyc + 1, 1'b0, 24'hDEADBE);
    nb = 0;
    @(negedge clk);
    tb_rd = 1'b0; tb_addr = 8'h00;
    if (m_busy) nb++;
    repeat (3) begin
      @(negedge clk);
      if (m_busy) nb++;
    end
    chk("ws0_busy_cycles", nb, 1);
    issue(0, 1'b1, 1'b1, 8'hFF, 24'h000001, 1'b1, 24'h0);
    issue(0, 1'b1, 1'b0, 8'hFF, 24'h0,      1'b0, 24'hDEADBE);

    // WAIT_STATES=1: held load strobe, address wiggled while busy
    sel = 2;
    issue(1, 1'b0, 1'b1, 8'h30, 24'h303030, 1'b0, 24'h0);
    issue(1, 1'b0, 1'b1, 8'h31, 24'h313131, 1'b0, 24'h0);
    @(negedge clk);
    c0 = cyc;
    for (int j = 0; j < 4; j++) push(c0 + 2 + 3 * j, 1'b0, 24'h303030);
    tb_rd = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tb_addr = (k % 3 == 0) ? 8'h30 : 8'h31;
      @(negedge clk);
    end
    tb_rd = 1'b0;

    for (int t = 0; t < 30 && sb.size() != 0; t++) @(negedge clk);
    chk("queue_drained", sb.size(), 0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
